pwm_deadtime_guard: RTL and testbench

PWM_DEADTIME_GUARD -- requirements
Module: pwm_deadtime_guard

---
 rtl/pwm_deadtime_guard.sv | 194 +++++++++++++++++++
 tb/tb_pwm_deadtime_guard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_guard.sv
// Three-phase gate-drive guard: enforces a dead time before each switch turns on and
// latches shoot-through / external trips. Each phase runs its own small FSM.

module pwm_deadtime_phase #(
    parameter int unsigned DT_CYCLES = 35
) (
    input  logic clk,
    input  logic reset,
    input  logic force_idle,
    input  logic in_p,
    input  logic in_n,
    output logic out_p,
    output logic out_n
);
    typedef enum logic [1:0] {IDLE, DEAD, P_ON, N_ON} state_t;

    localparam logic [7:0] RELOAD = 8'(DT_CYCLES - 1);

    state_t     state_q;
    logic       tgt_q;      // 0 = P side, 1 = N side
    logic [7:0] cnt_q;
    logic       out_p_q;
    logic       out_n_q;

    logic req_p;
    logic req_n;
    logic req_v;

    assign req_p = in_p & ~in_n;
    assign req_n = ~in_p & in_n;
    assign req_v = req_p | req_n;

    // Drive registers are loaded with the decode of the state being entered,
    // so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= 1'b0;
            cnt_q   <= 8'd0;
            out_p_q <= 1'b0;
            out_n_q <= 1'b0;
        end else begin
            out_p_q <= 1'b0;
            out_n_q <= 1'b0;
            if (force_idle) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (req_v) begin
                            state_q <= DEAD;
                            tgt_q   <= req_n;
                            cnt_q   <= RELOAD;
                        end
                    end
                    DEAD: begin
                        if (!req_v) begin
                            state_q <= IDLE;
                        end else if (req_n != tgt_q) begin
                            tgt_q <= req_n;
                            cnt_q <= RELOAD;
                        end else if (cnt_q == 8'd0) begin
                            state_q <= tgt_q ? N_ON : P_ON;
                            out_p_q <= ~tgt_q;
                            out_n_q <= tgt_q;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    P_ON: begin
                        if (req_p) begin
                            out_p_q <= 1'b1;
                        end else if (req_n) begin
                            state_q <= DEAD;
                            tgt_q   <= 1'b1;
                            cnt_q   <= RELOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    N_ON: begin
                        if (req_n) begin
                            out_n_q <= 1'b1;
                        end else if (req_p) begin
                            state_q <= DEAD;
                            tgt_q   <= 1'b0;
                            cnt_q   <= RELOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_p = out_p_q;
    assign out_n = out_n_q;
endmodule

module pwm_deadtime_guard #(
    parameter int unsigned DT_CYCLES = 35
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       inUA_P,
    input  logic       inUA_N,
    input  logic       inUB_P,
    input  logic       inUB_N,
    input  logic       inUC_P,
    input  logic       inUC_N,
    input  logic       fault_ext,
    input  logic       fault_clr,
    output logic       outUA_P,
    output logic       outUA_N,
    output logic       outUB_P,
    output logic       outUB_N,
    output logic       outUC_P,
    output logic       outUC_N,
    output logic       fault,
    output logic [3:0] fault_src
);
    localparam int NUM_LANES = 3;

    logic [NUM_LANES-1:0] in_p;
    logic [NUM_LANES-1:0] in_n;
    logic [NUM_LANES-1:0] out_p;
    logic [NUM_LANES-1:0] out_n;
    logic [NUM_LANES-1:0] shoot;

    logic       fault_q;
    logic       fault_d;
    logic [3:0] src_q;
    logic [3:0] src_d;
    logic [3:0] cause_src;
    logic       cause;
    logic       force_idle;

    assign in_p = {inUC_P, inUB_P, inUA_P};
    assign in_n = {inUC_N, inUB_N, inUA_N};

    assign shoot      = in_p & in_n;
    assign cause_src  = {fault_ext, shoot};
    assign cause      = |cause_src;
    // A cause kills the drives on the edge it is seen, not one cycle later.
    assign force_idle = ~en | cause | fault_q;

    always_comb begin
        fault_d = fault_q;
        src_d   = src_q;
        if (cause) begin
            fault_d = 1'b1;
            src_d   = src_q | cause_src;
        end else if (fault_clr) begin
            fault_d = 1'b0;
            src_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
            src_q   <= 4'd0;
        end else begin
            fault_q <= fault_d;
            src_q   <= src_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_phase
        pwm_deadtime_phase #(
            .DT_CYCLES (DT_CYCLES)
        ) u_phase (
            .clk        (clk),
            .reset      (reset),
            .force_idle (force_idle),
            .in_p       (in_p[g]),
            .in_n       (in_n[g]),
            .out_p      (out_p[g]),
            .out_n      (out_n[g])
        );
    end

    assign outUA_P   = out_p[0];
    assign outUA_N   = out_n[0];
    assign outUB_P   = out_p[1];
    assign outUB_N   = out_n[1];
    assign outUC_P   = out_p[2];
    assign outUC_N   = out_n[2];
    assign fault     = fault_q;
    assign fault_src = src_q;
endmodule

// File: tb/tb_pwm_deadtime_guard.sv
// Scoreboard bench: a request-run-length model predicts every output each cycle,
// plus directed checks at the dead-time and fault boundaries.

module tb_pwm_deadtime_guard;
    localparam int DT = 35;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] ip;
    logic [2:0] inn;
    logic       fext;
    logic       fclr;
    logic       outUA_P, outUA_N, outUB_P, outUB_N, outUC_P, outUC_N;
    logic       fault;
    logic [3:0] fault_src;

    int n_chk = 0;
    int n_bad = 0;

    int   run [3];
    bit   side[3];
    bit   fault_m;
    bit [3:0] src_m;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_deadtime_guard #(.DT_CYCLES(DT)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .inUA_P    (ip[0]),
        .inUA_N    (inn[0]),
        .inUB_P    (ip[1]),
        .inUB_N    (inn[1]),
        .inUC_P    (ip[2]),
        .inUC_N    (inn[2]),
        .fault_ext (fext),
        .fault_clr (fclr),
        .outUA_P   (outUA_P),
        .outUA_N   (outUA_N),
        .outUB_P   (outUB_P),
        .outUB_N   (outUB_N),
        .outUC_P   (outUC_P),
        .outUC_N   (outUC_N),
        .fault     (fault),
        .fault_src (fault_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {outUC_N, outUC_P, outUB_N, outUB_P, outUA_N, outUA_P, fault, fault_src};
    endfunction

    // An output side is on once the same valid request has been seen on more
    // than DT consecutive edges with nothing forcing the phase off.
    task automatic step();
        logic [3:0]  cs;
        bit          forced;
        logic [10:0] e;
        cs = {fext, ip & inn};
        if (reset) begin
            for (int p = 0; p < 3; p++) begin run[p] = 0; side[p] = 0; end
            fault_m = 0;
            src_m   = 0;
        end else begin
            forced = !en || fault_m || (cs != 0);
            for (int p = 0; p < 3; p++) begin
                if (forced || !(ip[p] ^ inn[p])) begin
                    run[p] = 0;
                end else if (run[p] > 0 && side[p] == inn[p]) begin
                    if (run[p] < 1000) run[p]++;
                end else begin
                    run[p]  = 1;
                    side[p] = inn[p];
                end
            end
            if (cs != 0) begin
                fault_m = 1;
                src_m   = src_m | cs;
            end else if (fclr) begin
                fault_m = 0;
                src_m   = 0;
            end
        end
        e = '0;
        for (int p = 0; p < 3; p++) begin
            e[5 + 2*p] = (run[p] > DT) && !side[p];
            e[6 + 2*p] = (run[p] > DT) && side[p];
        end
        e[4]   = fault_m;
        e[3:0] = src_m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("cyc", dut_vec(), exp_q.pop_front());
    endtask

    initial begin
        reset = 1; en = 0; ip = 0; inn = 0; fext = 0; fclr = 0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_state", dut_vec(), 11'd0);
        reset = 0; en = 1;

        // Turn-on dead time on phase A
        ip[0] = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("a_n_off", outUA_N, 1'b0);
            if (i == 34) chk("a_p_dead_end", outUA_P, 1'b0);
            if (i == 35) chk("a_p_on", outUA_P, 1'b1);
        end

        // P -> N changeover
        ip[0] = 0; inn[0] = 1;
        for (int i = 0; i < 38; i++) begin
            step();
            chk("a_ovl", outUA_P & outUA_N, 1'b0);
            if (i == 0)  chk("a_p_off", outUA_P, 1'b0);
            if (i == 34) chk("a_n_dead_end", outUA_N, 1'b0);
            if (i == 35) chk("a_n_on", outUA_N, 1'b1);
        end

        // Toggling faster than the dead time never turns anything on
        for (int i = 0; i < 60; i++) begin
            ip  = ((i / 10) % 2 == 0) ? 3'b111 : 3'b000;
            inn = ~ip;
            step();
            chk("tog_outs", dut_vec() >> 5, 6'd0);
        end
        chk("tog_fault", fault, 1'b0);

        // Shoot-through on B while A and C are on
        ip = 3'b001; inn = 3'b100;
        for (int i = 0; i < 37; i++) step();
        chk("ac_on", {outUC_N, outUA_P}, 2'b11);
        ip[1] = 1; inn[1] = 1;
        step();
        chk("st_outs", dut_vec() >> 5, 6'd0);
        chk("st_fault", fault, 1'b1);
        chk("st_src", fault_src, 4'b0010);
        ip[1] = 0; inn[1] = 0;
        step();
        chk("st_hold", fault, 1'b1);
        fclr = 1;
        step();
        fclr = 0;
        chk("clr_fault", fault, 1'b0);
        chk("clr_src", fault_src, 4'd0);
        for (int i = 1; i <= 36; i++) begin
            step();
            if (i == 35) chk("a_re_dead", outUA_P, 1'b0);
            if (i == 36) chk("a_re_on", outUA_P, 1'b1);
        end

        // External trip held with clear asserted
        fext = 1; fclr = 1;
        for (int i = 0; i < 5; i++) step();
        chk("ext_fault", fault, 1'b1);
        chk("ext_src", fault_src, 4'b1000);
        chk("ext_outs", dut_vec() >> 5, 6'd0);
        fext = 0;
        step();
        chk("ext_clr", {fault, fault_src}, 5'd0);
        fclr = 0;

        // en low: drives off, no fault
        for (int i = 0; i < 37; i++) step();
        en = 0;
        step();
        chk("en_off", dut_vec(), 11'd0);
        en = 1;

        // Reset in mid dead time (cnt = 10), then reset during fault
        ip = 0; inn = 0;
        step();
        ip[0] = 1;
        for (int i = 0; i < 25; i++) step();
        reset = 1;
        step();
        chk("rst_dead", dut_vec(), 11'd0);
        reset = 0;
        fext = 1;
        step();
        fext = 0;
        chk("pre_rst_fault", fault, 1'b1);
        reset = 1;
        step();
        chk("rst_fault", dut_vec(), 11'd0);
        reset = 0;
        for (int i = 0; i < 38; i++) step();
        chk("post_rst_on", outUA_P, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
